led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
Multi-channel LED pattern generator, parametrised successor of the single-shot/blink LED driver.
- Each channel latches its own mode, on-time, period and pulse count at start.
- Each channel runs an independent ms-resolution phase FSM.
- Sits between the status/control register file and the front-panel LED pins. Reports per-channel busy back to the register file.

Parameters:
LED_NUM, 4, number of LED channels
SYSCLK_RATE, 100, clk frequency in MHz; one ms = SYSCLK_RATE*1000 cycles
TIME_W, 16, width of on_ms / period_ms fields (ms)
CNT_W, 8, width of pulse_cnt field

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
mode  input  [LED_NUM-1:0][2:0]  0 OFF, 1 ON, 2 SINGLE, 3 BLINK_N, 4 BLINK_CONT, 5-7 = OFF
on_ms  input  [LED_NUM-1:0][TIME_W-1:0]  lit-phase length, ms
period_ms  input  [LED_NUM-1:0][TIME_W-1:0]  blink period, ms
pulse_cnt  input  [LED_NUM-1:0][CNT_W-1:0]  pulses for BLINK_N
start  input  [LED_NUM-1:0]  one-cycle start/retrigger strobe per channel
stop  input  [LED_NUM-1:0]  one-cycle stop strobe per channel
led_out  output  [LED_NUM-1:0]  LED drive, 1 = lit
busy  output  [LED_NUM-1:0]  channel not in IDLE

Behaviour:
- Reset: led_out = 0, busy = 0, all FSMs IDLE, all counters 0, latched config 0. Applies at any time, including mid-pattern.
- Per-channel logic:
  - prescaler counts 0..SYSCLK_RATE*1000-1 and is cleared on start.
  - ms counter advances on prescaler wrap.
  - pulse counter counts completed pulses.
- FSM states are IDLE, LIT, DARK.
- Start (stop not asserted, latched mode 1-4): on edge N, latch mode/on_ms/period_ms/pulse_cnt and enter LIT. led_out = 1 from cycle N+1; busy = 1 from N+1.
- Start with mode OFF/5-7: ignored; channel stays or goes IDLE with led_out = 0.
- LIT ends after exactly max(on_ms,1)*SYSCLK_RATE*1000 cycles. Exit by mode:
  - ON: never leaves LIT until stop.
  - SINGLE: goes to IDLE (led_out = 0, busy = 0).
  - BLINK_N: increments pulse counter; if count == max(pulse_cnt,1), goes to IDLE, else goes to DARK.
  - BLINK_CONT: goes to DARK.
- DARK lasts (period_ms - on_ms) ms. If period_ms <= on_ms (unsigned compare), DARK lasts 1 ms. Then LIT again, led_out = 0 throughout DARK.
- Stop: next cycle IDLE, led_out = 0, busy = 0, counters cleared. Stop in IDLE has no effect.
- Start while busy: retrigger. Re-latch config, clear counters, enter LIT; the pattern restarts from pulse 0.
- Start and stop in the same cycle: stop wins.
- Input changes to mode/on_ms/period_ms/pulse_cnt while busy have no effect until the next start.
- Channels are fully independent; simultaneous starts on all channels are legal.
- Counter widths must hold TIME_W ms without overflow. Prescaler width is ceil(log2(SYSCLK_RATE*1000)).

Optional Feature:
LED_PWM_EN
- Defined:
  - Adds input brightness [LED_NUM-1:0][7:0].
  - A shared free-running 8-bit PWM counter runs from reset = 0.
  - In LIT, led_out = (pwm_cnt < brightness); brightness 0 gives dark; 255 gives lit 255/256 of cycles.
  - Brightness is sampled live, not latched.
  - DARK/IDLE behaviour is unchanged.
- Undefined: no brightness port; led_out = 1 for the whole LIT phase.

Test Plan:
(SYSCLK_RATE = 1, i.e. 1 ms = 1000 cycles)
- Reset mid-pattern: reset pulse during BLINK_CONT LIT -> led_out/busy = 0 immediately (asynchronous); the next start after deassertion behaves normally.
- SINGLE, on_ms = 3, start ch0 -> led_out[0] high for exactly 3000 cycles starting the cycle after start, then low; busy[0] drops in the same cycle; other channels stay 0.
- BLINK_N, on_ms = 1, period_ms = 4, pulse_cnt = 3 -> 3 high pulses of 1000 cycles each, spaced 4000 cycles rising-to-rising, then IDLE.
- BLINK_CONT on ch1, stop at cycle 6500 -> led_out[1] = 0 and busy[1] = 0 at 6501; start+stop in the same cycle -> stays IDLE.
- Retrigger: SINGLE on_ms = 5, second start at cycle 2000 with on_ms = 2 -> led stays lit until cycle 4000 (2000 after retrigger); edge cases on_ms = 0 -> 1000-cycle pulse, period_ms = on_ms -> 1000-cycle DARK.
- LED_PWM_EN defined, mode ON, brightness = 64 -> led_out high 64 of every 256 cycles; brightness 0 -> constant 0 while busy = 1.

Source files
------------

// File: rtl/led_sequencer.sv
// led_sequencer: LED_NUM independent LED pattern channels (OFF/ON/SINGLE/BLINK_N/BLINK_CONT), ms timing via prescaler.
// Start/stop act on the next cycle, and there is no backpressure. Define LED_PWM_EN to add per-channel live brightness PWM during LIT.
module led_sequencer #(
  parameter int LED_NUM     = 4,
  parameter int SYSCLK_RATE = 100,
  parameter int TIME_W      = 16,
  parameter int CNT_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef LED_PWM_EN
  input  logic [LED_NUM-1:0][7:0]        brightness,
`endif
  input  logic [LED_NUM-1:0][2:0]        mode,
  input  logic [LED_NUM-1:0][TIME_W-1:0] on_ms,
  input  logic [LED_NUM-1:0][TIME_W-1:0] period_ms,
  input  logic [LED_NUM-1:0][CNT_W-1:0]  pulse_cnt,
  input  logic [LED_NUM-1:0]             start,
  input  logic [LED_NUM-1:0]             stop,
  output logic [LED_NUM-1:0]             led_out,
  output logic [LED_NUM-1:0]             busy
);

  localparam int PRE_CYC = SYSCLK_RATE * 1000;
  localparam int PRE_W   = $clog2(PRE_CYC);

  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRE_CYC - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] MODE_ON         = 3'd1;
  localparam logic [2:0] MODE_SINGLE     = 3'd2;
  localparam logic [2:0] MODE_BLINK_N    = 3'd3;
  localparam logic [2:0] MODE_BLINK_CONT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LIT  = 2'd1,
    ST_DARK = 2'd2
  } state_e;

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

  for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
    state_e             state_q, state_d;
    logic [2:0]         mode_q, mode_d;
    logic [TIME_W-1:0]  on_q, on_d;
    logic [TIME_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [TIME_W-1:0]  ms_q, ms_d;
    logic [CNT_W-1:0]   pulses_q, pulses_d;

    logic               pre_wrap;
    logic               mode_valid;
    logic [TIME_W-1:0]  lit_last;
    logic [TIME_W-1:0]  dark_last;
    logic [CNT_W-1:0]   pulse_tgt;
    logic [CNT_W-1:0]   pulses_inc;
    logic               lit;

    assign pre_wrap   = (pre_q == PRE_MAX);
    assign mode_valid = (mode[i] != 3'd0) && (mode[i] <= MODE_BLINK_CONT);
    // Last ms index of each phase; zero-length phases stretch to 1 ms.
    assign lit_last   = (on_q == '0) ? '0 : on_q - TIME_ONE;
    assign dark_last  = (per_q > on_q) ? per_q - on_q - TIME_ONE : '0;
    assign pulse_tgt  = (pcnt_q == '0) ? CNT_ONE : pcnt_q;
    assign pulses_inc = pulses_q + CNT_ONE;

    always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      on_d     = on_q;
      per_d    = per_q;
      pcnt_d   = pcnt_q;
      pre_d    = pre_q;
      ms_d     = ms_q;
      pulses_d = pulses_q;

      if (stop[i]) begin
        state_d  = ST_IDLE;
        pre_d    = '0;
        ms_d     = '0;
        pulses_d = '0;
      end else if (start[i]) begin
        // Retrigger restarts the pattern from pulse 0 with freshly latched config.
        pre_d    = '0;
        ms_d     = '0;
        pulses_d = '0;
        if (mode_valid) begin
          state_d = ST_LIT;
          mode_d  = mode[i];
          on_d    = on_ms[i];
          per_d   = period_ms[i];
          pcnt_d  = pulse_cnt[i];
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        unique case (state_q)
          ST_LIT: begin
            if (mode_q != MODE_ON) begin
              pre_d = pre_wrap ? '0 : pre_q + PRE_ONE;
              if (pre_wrap) begin
                if (ms_q == lit_last) begin
                  ms_d = '0;
                  case (mode_q)
                    MODE_BLINK_N: begin
                      if (pulses_inc == pulse_tgt) begin
                        state_d  = ST_IDLE;
                        pulses_d = '0;
                      end else begin
                        state_d  = ST_DARK;
                        pulses_d = pulses_inc;
                      end
                    end
                    MODE_BLINK_CONT: state_d = ST_DARK;
                    MODE_SINGLE:     state_d = ST_IDLE;
                    default:         state_d = ST_IDLE;
                  endcase
                end else begin
                  ms_d = ms_q + TIME_ONE;
                end
              end
            end
          end
          ST_DARK: begin
            pre_d = pre_wrap ? '0 : pre_q + PRE_ONE;
            if (pre_wrap) begin
              if (ms_q == dark_last) begin
                ms_d    = '0;
                state_d = ST_LIT;
              end else begin
                ms_d = ms_q + TIME_ONE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        mode_q   <= '0;
        on_q     <= '0;
        per_q    <= '0;
        pcnt_q   <= '0;
        pre_q    <= '0;
        ms_q     <= '0;
        pulses_q <= '0;
      end else begin
        state_q  <= state_d;
        mode_q   <= mode_d;
        on_q     <= on_d;
        per_q    <= per_d;
        pcnt_q   <= pcnt_d;
        pre_q    <= pre_d;
        ms_q     <= ms_d;
        pulses_q <= pulses_d;
      end
    end

    // Outputs decode straight from the state register so reset clears them immediately.
    assign lit     = (state_q == ST_LIT);
    assign busy[i] = (state_q != ST_IDLE);
`ifdef LED_PWM_EN
    assign led_out[i] = lit && (pwm_cnt_q < brightness[i]);
`else
    assign led_out[i] = lit;
`endif
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with SYSCLK_RATE = 1 (1 ms = 1000 cycles).
module tb_led_sequencer;
  localparam int N  = 4;
  localparam int TW = 16;
  localparam int CW = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [N-1:0][2:0]      mode = '0;
  logic [N-1:0][TW-1:0]   on_ms = '0;
  logic [N-1:0][TW-1:0]   period_ms = '0;
  logic [N-1:0][CW-1:0]   pulse_cnt = '0;
  logic [N-1:0]           start = '0;
  logic [N-1:0]           stop = '0;
  logic [N-1:0]           led_out;
  logic [N-1:0]           busy;
`ifdef LED_PWM_EN
  logic [N-1:0][7:0]      brightness = '0;
`endif

  led_sequencer #(.LED_NUM(N), .SYSCLK_RATE(1), .TIME_W(TW), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
`ifdef LED_PWM_EN
    .brightness(brightness),
`endif
    .mode(mode),
    .on_ms(on_ms),
    .period_ms(period_ms),
    .pulse_cnt(pulse_cnt),
    .start(start),
    .stop(stop),
    .led_out(led_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string      name;
    int         ch;
    logic [2:0] md;
    int         on;
    int         per;
    int         pc;
    int         win;
    int         exp_hi;
    int         exp_dark;
    int         exp_pulses;
    int         exp_busy;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int ch, input logic [2:0] md, input int on, input int per, input int pc);
    mode[ch]      = md;
    on_ms[ch]     = TW'(on);
    period_ms[ch] = TW'(per);
    pulse_cnt[ch] = CW'(pc);
    start[ch]     = 1'b1;
    tick();
    start[ch]     = 1'b0;
  endtask

  task automatic halt(input int ch);
    stop[ch] = 1'b1;
    tick();
    stop[ch] = 1'b0;
    tick();
  endtask

  // Starts a vector, then profiles the channel over its window cycle by cycle.
  task automatic measure(input vec_t v);
    int phase, hi, dark, pulses, busy_len, quiet;
    logic prev, dropped;
    logic [N-1:0] others;
    phase = 0; hi = 0; dark = 0; pulses = 0; busy_len = 0; quiet = 0;
    prev = 1'b0; dropped = 1'b0;
    others = ~(N'(1) << v.ch);
    launch(v.ch, v.md, v.on, v.per, v.pc);
    for (int k = 0; k < v.win; k++) begin
      if (led_out[v.ch]) begin
        if (phase == 0) phase = 1;
        else if (phase == 2) phase = 3;
        if (phase == 1) hi++;
        if (!prev) pulses++;
      end else begin
        if (phase == 1) phase = 2;
        if (phase == 2 && busy[v.ch]) dark++;
      end
      prev = led_out[v.ch];
      if (!busy[v.ch]) dropped = 1'b1;
      else if (!dropped) busy_len++;
      if (((led_out | busy) & others) != '0) quiet++;
      tick();
    end
    chk({v.name, ".hi"}, hi, v.exp_hi);
    chk({v.name, ".dark"}, dark, v.exp_dark);
    chk({v.name, ".pulses"}, pulses, v.exp_pulses);
    chk({v.name, ".busy"}, busy_len, v.exp_busy);
    chk({v.name, ".others"}, quiet, 0);
    halt(v.ch);
  endtask

  initial begin
    int cnt, rises;
    logic prev;
    vec_t v;

    //          name         ch md    on per pc  win    hi    dark  pulses busy
    tbl[0] = '{"single3",    0, 3'd2, 3, 0,  0,  4000,  3000, 0,    1,     3000};
    tbl[1] = '{"single0",    1, 3'd2, 0, 0,  0,  2000,  1000, 0,    1,     1000};
    tbl[2] = '{"blinkn3",    2, 3'd3, 1, 4,  3,  10000, 1000, 3000, 3,     9000};
    tbl[3] = '{"cont_eq",    1, 3'd4, 2, 2,  0,  6000,  2000, 1000, 2,     6000};
    tbl[4] = '{"blinkn_lt",  3, 3'd3, 2, 1,  2,  6000,  2000, 1000, 2,     5000};
    tbl[5] = '{"blinkn_pc0", 0, 3'd3, 1, 3,  0,  2000,  1000, 0,    1,     1000};
    tbl[6] = '{"mode5",      2, 3'd5, 2, 4,  2,  100,   0,    0,    0,     0};
    tbl[7] = '{"mode_off",   3, 3'd0, 2, 4,  2,  100,   0,    0,    0,     0};
    tbl[8] = '{"on",         3, 3'd1, 1, 0,  0,  3000,  3000, 0,    1,     3000};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset.led", int'(led_out), 0);
    chk("reset.busy", int'(busy), 0);
    tick();

    // Asynchronous reset in the middle of a BLINK_CONT lit phase.
    launch(0, 3'd4, 1, 2, 0);
    repeat (499) tick();
    chk("mid.busy_before", int'(busy[0]), 1);
    chk("mid.led_before", int'(led_out[0]), 1);
    #1 reset = 1'b1;
    #1;
    chk("mid.led_async", int'(led_out), 0);
    chk("mid.busy_async", int'(busy), 0);
    #1 reset = 1'b0;
    tick();
    v = '{"after_rst", 0, 3'd2, 1, 0, 0, 2000, 1000, 0, 1, 1000};
    measure(v);

`ifdef LED_PWM_EN
    brightness[0] = 8'd64;
    launch(0, 3'd1, 1, 0, 0);
    cnt = 0;
    for (int k = 0; k < 512; k++) begin
      if (led_out[0]) cnt++;
      tick();
    end
    chk("pwm64.high", cnt, 128);
    chk("pwm64.busy", int'(busy[0]), 1);
    brightness[0] = 8'd0;
    cnt = 0;
    for (int k = 0; k < 512; k++) begin
      if (led_out[0]) cnt++;
      tick();
    end
    chk("pwm0.high", cnt, 0);
    chk("pwm0.busy", int'(busy[0]), 1);
    halt(0);
`else
    foreach (tbl[i]) measure(tbl[i]);

    // Stop at cycle 6500 of a BLINK_CONT pattern.
    launch(1, 3'd4, 1, 2, 0);
    repeat (6499) tick();
    chk("stop.led_6500", int'(led_out[1]), 1);
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    chk("stop.led_6501", int'(led_out[1]), 0);
    chk("stop.busy_6501", int'(busy[1]), 0);
    tick();

    // Start and stop together: stop wins, both from IDLE and while busy.
    stop[1] = 1'b1;
    launch(1, 3'd2, 1, 0, 0);
    stop[1] = 1'b0;
    chk("ss_idle.busy", int'(busy[1]), 0);
    tick();
    chk("ss_idle.led", int'(led_out[1]), 0);
    launch(1, 3'd4, 1, 2, 0);
    repeat (10) tick();
    chk("ss_busy.before", int'(busy[1]), 1);
    stop[1] = 1'b1;
    launch(1, 3'd4, 1, 2, 0);
    stop[1] = 1'b0;
    chk("ss_busy.after", int'(busy[1]), 0);
    tick();

    // Retrigger at cycle 2000; the live on_ms change to 1 must be ignored.
    launch(2, 3'd2, 5, 0, 0);
    on_ms[2] = TW'(1);
    repeat (1999) tick();
    chk("retrig.led_2000", int'(led_out[2]), 1);
    launch(2, 3'd2, 2, 0, 0);
    cnt = 0;
    while (led_out[2] && cnt < 10000) begin
      cnt++;
      tick();
    end
    chk("retrig.lit_len", cnt, 2000);
    chk("retrig.busy_end", int'(busy[2]), 0);
    tick();

    // Retrigger of BLINK_N during DARK restarts from pulse 0.
    launch(3, 3'd3, 1, 2, 2);
    repeat (1499) tick();
    chk("rtn.dark", int'(led_out[3]), 0);
    launch(3, 3'd3, 1, 2, 2);
    rises = 0; cnt = 0; prev = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (led_out[3] && !prev) rises++;
      if (busy[3]) cnt++;
      prev = led_out[3];
      tick();
    end
    chk("rtn.pulses", rises, 2);
    chk("rtn.busy", cnt, 3000);

    // Start with an invalid mode while busy sends the channel idle.
    launch(0, 3'd1, 1, 0, 0);
    repeat (5) tick();
    chk("inv.before", int'(busy[0]), 1);
    launch(0, 3'd6, 1, 0, 0);
    chk("inv.busy", int'(busy[0]), 0);
    chk("inv.led", int'(led_out[0]), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
